// File: rtl/gmii_frame_gen_if.sv
// rtl/gmii_frame_gen_if.sv - GMII receive bus plus frame-memory read port
interface gmii_frame_gen_if #(
    parameter int AW = 13
);
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic [7:0]    rxd;
    logic          rx_dv;
    logic          rx_er;

    modport master (output mem_addr, input mem_data, output rxd, output rx_dv, output rx_er);
    modport slave  (input mem_addr, output mem_data, input rxd, input rx_dv, input rx_er);
endinterface

// File: rtl/gmii_frame_gen.sv
// rtl/gmii_frame_gen.sv - GMII rx frame generator with preamble, padding, FCS, gap and repeat
// Optional error injection on DATA bytes when GMII_FRAME_GEN_ERRINJ_EN is defined.
module gmii_frame_gen #(
    parameter int MAXNBYTES = 1536,
    parameter int NSLOTS    = 4,
    parameter int AW        = 13,
    parameter int IFG_MIN   = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic [$clog2(NSLOTS)-1:0] slot,
    input  logic [15:0]               nbytes,
    input  logic [15:0]               count,
    input  logic [15:0]               ifg,
`ifdef GMII_FRAME_GEN_ERRINJ_EN
    input  logic                      err_en,
    input  logic [15:0]               err_idx,
`endif
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               frames,
    gmii_frame_gen_if.master          gm
);
    localparam logic [15:0] MAXN    = 16'(MAXNBYTES);
    localparam logic [15:0] MIN_LEN = 16'd60;
    localparam logic [15:0] MIN_GAP = 16'(IFG_MIN);

    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, FCS, GAP} state_t;

    state_t        state;
    logic [2:0]    cnt;
    logic [15:0]   idx;
    logic [15:0]   len_q;
    logic [15:0]   dlen_q;
    logic [15:0]   gap_q;
    logic [15:0]   count_q;
    logic [AW-1:0] base_q;
    logic [31:0]   crc;

    logic [15:0]   eff_len;
    logic [15:0]   data_len;
    logic [15:0]   gap_len;
    logic [AW-1:0] slot_base;
    logic [7:0]    data_byte;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    always_comb begin
        eff_len   = (nbytes > MAXN) ? MAXN : nbytes;
        data_len  = (eff_len < MIN_LEN) ? MIN_LEN : eff_len;
        gap_len   = (ifg < MIN_GAP) ? MIN_GAP : ifg;
        slot_base = AW'(int'(slot) * MAXNBYTES);
        // Beyond the effective length the body is zero padding; memory is not consulted.
        data_byte = (idx < len_q) ? gm.mem_data : 8'h00;
    end

`ifdef GMII_FRAME_GEN_ERRINJ_EN
    logic        er_en_q;
    logic [15:0] er_idx_q;
`else
    assign gm.rx_er = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            len_q       <= '0;
            dlen_q      <= '0;
            gap_q       <= '0;
            count_q     <= '0;
            base_q      <= '0;
            crc         <= '1;
            gm.mem_addr <= '0;
            gm.rxd      <= '0;
            gm.rx_dv    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frames      <= '0;
`ifdef GMII_FRAME_GEN_ERRINJ_EN
            er_en_q     <= 1'b0;
            er_idx_q    <= '0;
            gm.rx_er    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef GMII_FRAME_GEN_ERRINJ_EN
            gm.rx_er <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // The done cycle itself still blocks a new start.
                    if (start && !done) begin
                        len_q    <= eff_len;
                        dlen_q   <= data_len;
                        gap_q    <= gap_len;
                        count_q  <= count;
                        base_q   <= slot_base;
                        frames   <= '0;
                        busy     <= 1'b1;
`ifdef GMII_FRAME_GEN_ERRINJ_EN
                        er_en_q  <= err_en;
                        er_idx_q <= err_idx;
`endif
                        state    <= PRE;
                        cnt      <= '0;
                        crc      <= '1;
                        gm.rxd   <= 8'h55;
                        gm.rx_dv <= 1'b1;
                    end
                end
                PRE: begin
                    if (cnt == 3'd6) begin
                        state       <= SFD;
                        gm.rxd      <= 8'hD5;
                        gm.mem_addr <= base_q;
                        idx         <= '0;
                    end else begin
                        cnt    <= cnt + 3'd1;
                        gm.rxd <= 8'h55;
                    end
                end
                SFD, DATA: begin
                    if (idx == dlen_q) begin
                        state  <= FCS;
                        cnt    <= 3'd1;
                        gm.rxd <= ~crc[7:0];
                        crc    <= {8'h00, crc[31:8]};
                    end else begin
                        state  <= DATA;
                        gm.rxd <= data_byte;
                        crc    <= crc_upd(crc, data_byte);
                        idx    <= idx + 16'd1;
                        if (idx + 16'd1 < len_q)
                            gm.mem_addr <= base_q + AW'(idx + 16'd1);
`ifdef GMII_FRAME_GEN_ERRINJ_EN
                        gm.rx_er <= er_en_q && (idx == er_idx_q);
`endif
                    end
                end
                FCS: begin
                    if (cnt == 3'd4) begin
                        state    <= GAP;
                        gm.rx_dv <= 1'b0;
                        gm.rxd   <= '0;
                        idx      <= 16'd1;
                    end else begin
                        gm.rxd <= ~crc[7:0];
                        crc    <= {8'h00, crc[31:8]};
                        cnt    <= cnt + 3'd1;
                        if (cnt == 3'd3)
                            frames <= frames + 16'd1;
                    end
                end
                GAP: begin
                    if (idx >= gap_q) begin
                        if (stop || (count_q != 16'd0 && frames == count_q)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= PRE;
                            cnt      <= '0;
                            crc      <= '1;
                            gm.rxd   <= 8'h55;
                            gm.rx_dv <= 1'b1;
                        end
                    end else begin
                        idx <= idx + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gmii_frame_gen.sv
// tb/tb_gmii_frame_gen.sv - scoreboard bench for gmii_frame_gen
module tb_gmii_frame_gen;
    localparam int MAXNBYTES = 1536;
    localparam int NSLOTS    = 4;
    localparam int AW        = 13;
    localparam int IFG_MIN   = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  slot = '0;
    logic [15:0] nbytes = '0;
    logic [15:0] count = '0;
    logic [15:0] ifg = '0;
    logic        busy;
    logic        done;
    logic [15:0] frames;
`ifdef GMII_FRAME_GEN_ERRINJ_EN
    logic        err_en = 1'b0;
    logic [15:0] err_idx = '0;
`endif

    logic [7:0] mem [0:(1<<AW)-1];
    gmii_frame_gen_if #(.AW(AW)) gm ();
    assign gm.mem_data = mem[gm.mem_addr];

    gmii_frame_gen #(.MAXNBYTES(MAXNBYTES), .NSLOTS(NSLOTS), .AW(AW), .IFG_MIN(IFG_MIN)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .stop   (stop),
        .slot   (slot),
        .nbytes (nbytes),
        .count  (count),
        .ifg    (ifg),
`ifdef GMII_FRAME_GEN_ERRINJ_EN
        .err_en (err_en),
        .err_idx(err_idx),
`endif
        .busy   (busy),
        .done   (done),
        .frames (frames),
        .gm     (gm)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++) begin
            if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    logic [8:0] exp_q [$];
    int         len_q [$];
    int         exp_gap = 0;

    task automatic push_frame(input int s, input int nb, input int er_idx);
        int          l;
        int          d;
        logic [31:0] c;
        logic [7:0]  b;
        l = (nb > MAXNBYTES) ? MAXNBYTES : nb;
        d = (l < 60) ? 60 : l;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        for (int i = 0; i < d; i++) begin
            b = (i < l) ? mem[s * MAXNBYTES + i] : 8'h00;
            c = crc_bit(c, b);
            exp_q.push_back({(i == er_idx), b});
        end
        c = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, c[8*k +: 8]});
        len_q.push_back(8 + d + 4);
    endtask

    int         run = 0;
    int         gap = 0;
    int         rises = 0;
    int         dones = 0;
    logic       prev_dv = 1'b0;
    logic [8:0] mon_e;

    always @(negedge clk) begin
        if (reset) begin
            run = 0;
            gap = 0;
            prev_dv = 1'b0;
        end else begin
            if (gm.rx_dv) begin
                if (!prev_dv) begin
                    rises++;
                    if (gap != 0) chk("gap_between_frames", 32'(gap), 32'(exp_gap));
                    gap = 0;
                end
                run++;
                chk("busy_with_dv", 32'(busy), 32'd1);
                chk("byte_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("rxd", 32'(gm.rxd), 32'(mon_e[7:0]));
                    chk("rx_er", 32'(gm.rx_er), 32'(mon_e[8]));
                end
            end else begin
                if (prev_dv) begin
                    chk("dv_length", 32'(run), (len_q.size() > 0) ? 32'(len_q.pop_front()) : 32'hFFFFFFFF);
                    run = 0;
                end
                chk("rx_er_idle", 32'(gm.rx_er), 32'd0);
                if (busy) gap++;
            end
            if (done) begin
                dones++;
                chk("gap_before_done", 32'(gap), 32'(exp_gap));
                gap = 0;
            end
            prev_dv = gm.rx_dv;
        end
    end

    task automatic do_start(input int s, input int nb, input int cnt, input int g);
        @(negedge clk);
        slot   = 2'(s);
        nbytes = 16'(nb);
        count  = 16'(cnt);
        ifg    = 16'(g);
        start  = 1'b1;
        exp_gap = (g < IFG_MIN) ? IFG_MIN : g;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("dv_after_start", 32'(gm.rx_dv), 32'd1);
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int exp_frames);
        int i;
        int d0;
        i = 0;
        d0 = dones;
        while (done !== 1'b1 && i < 20000) begin
            @(negedge clk);
            i++;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("frames", 32'(frames), 32'(exp_frames));
        chk("busy_low_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_is_pulse", 32'(done), 32'd0);
        chk("one_done", 32'(dones - d0), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    logic [7:0] arp_hdr [42] = '{
        8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hc4, 8'h6e, 8'h1f, 8'h00, 8'h00, 8'h01,
        8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
        8'hc4, 8'h6e, 8'h1f, 8'h00, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h01, 8'h02,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hc0, 8'ha8, 8'h01, 8'h01};
    logic [7:0] ping_hdr [6] = '{8'h00, 8'h10, 8'h5a, 8'hd1, 8'h55, 8'hb2};

    initial begin
        int r0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom_range(1, 255));
        for (int i = 0; i < 60; i++) mem[i] = (i < 42) ? arp_hdr[i] : 8'h00;
        for (int i = 0; i < 6; i++) mem[MAXNBYTES + i] = ping_hdr[i];

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rxd", 32'(gm.rxd), 32'd0);
        chk("reset_rx_dv", 32'(gm.rx_dv), 32'd0);
        chk("reset_rx_er", 32'(gm.rx_er), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_frames", 32'(frames), 32'd0);
        chk("reset_mem_addr", 32'(gm.mem_addr), 32'd0);
        reset = 1'b0;

        // ARP request, then ICMP echo, padding, empty body and over-long body
        push_frame(0, 60, -1);    do_start(0, 60, 1, 12);    wait_done(1);
        push_frame(1, 98, -1);    do_start(1, 98, 1, 12);    wait_done(1);
        push_frame(2, 20, -1);    do_start(2, 20, 1, 12);    wait_done(1);
        push_frame(2, 0, -1);     do_start(2, 0, 1, 3);      wait_done(1);
        push_frame(3, 2000, -1);  do_start(3, 2000, 1, 12);  wait_done(1);

        // Repeat with gap clamped up to the minimum
        for (int k = 0; k < 3; k++) push_frame(0, 60, -1);
        r0 = rises;
        do_start(0, 60, 3, 5);
        wait_done(3);
        chk("repeat_rises", 32'(rises - r0), 32'd3);

        // Continuous mode ended by stop during the second frame
        push_frame(0, 60, -1);
        push_frame(0, 60, -1);
        r0 = rises;
        do_start(0, 60, 0, 20);
        for (int i = 0; i < 1000 && rises < r0 + 2; i++) @(negedge clk);
        chk("second_frame_began", 32'(rises - r0), 32'd2);
        repeat (20) @(negedge clk);
        stop = 1'b1;
        wait_done(2);
        stop = 1'b0;

        // Start while busy is ignored
        push_frame(1, 98, -1);
        do_start(1, 98, 1, 12);
        repeat (30) @(negedge clk);
        slot = 2'd3; nbytes = 16'd10; count = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1);
        r0 = rises;
        repeat (100) @(negedge clk);
        chk("no_extra_frame", 32'(rises - r0), 32'd0);
        chk("idle_after_ignored_start", 32'(busy), 32'd0);

        // Reset during DATA cycle 30
        push_frame(0, 60, -1);
        do_start(0, 60, 1, 12);
        repeat (38) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_rx_dv", 32'(gm.rx_dv), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_rxd", 32'(gm.rxd), 32'd0);
        chk("midreset_mem_addr", 32'(gm.mem_addr), 32'd0);
        exp_q.delete();
        len_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_frame(2, 20, -1);    do_start(2, 20, 1, 12);    wait_done(1);

`ifdef GMII_FRAME_GEN_ERRINJ_EN
        err_en = 1'b1;
        err_idx = 16'd14;
        push_frame(0, 60, 14);    do_start(0, 60, 1, 12);    wait_done(1);
        err_idx = 16'd70;
        push_frame(0, 60, -1);    do_start(0, 60, 1, 12);    wait_done(1);
        err_en = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
